// File: rtl/pwm_compare_deadtime_pkg.sv
// Shared types and widths for the PWM compare / dead-time leg.
package pwm_compare_deadtime_pkg;

    localparam int PWMCOUNT_WIDTH = 16;
    localparam int DEADTIME_WIDTH = 10;

    typedef enum logic {
        PWM_OFF = 1'b0,
        PWM_ON  = 1'b1
    } pwm_onoff_e;

    typedef enum logic [2:0] {
        DT_OFF  = 3'd0,
        DT_H_ON = 3'd1,
        DT_HL   = 3'd2,
        DT_L_ON = 3'd3,
        DT_LH   = 3'd4
    } dt_state_e;

    // Gate pair for a given state; returns {high, low}. The inactive level equals
    // the polarity bit, so with polarity 0 both gates idle low.
    function automatic logic [1:0] gateDecode(input dt_state_e state, input logic pol);
        logic hiActive;
        logic loActive;
        hiActive = (state == DT_H_ON);
        loActive = (state == DT_L_ON);
        return {hiActive ? ~pol : pol, loActive ? ~pol : pol};
    endfunction

endpackage

// File: rtl/pwm_compare_deadtime_fsm.sv
// Dead-time state machine: follows the registered compare result, inserts a
// programmable both-off gap on every leg change and registers the gate pair.
module pwm_compare_deadtime_fsm
    import pwm_compare_deadtime_pkg::*;
#(
    parameter int DT_W = DEADTIME_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ref_i,
    input  pwm_onoff_e      pwm_onoff_i,
    input  logic [DT_W-1:0] deadtime_sh_i,
    input  logic            polarity_sh_d_i,
    output dt_state_e       state_o,
    output logic            pwm_h_o,
    output logic            pwm_l_o
);

    dt_state_e       state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            pwm_h_q, pwm_h_d;
    logic            pwm_l_q, pwm_l_d;
    logic            dtZero;
    logic [DT_W-1:0] dtLoad;

    assign dtZero = (deadtime_sh_i == '0);
    assign dtLoad = deadtime_sh_i - DT_W'(1);

    // Next state: leg off overrides everything; a ref change that reverts during
    // the gap cancels the switch and returns straight to the original leg.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (pwm_onoff_i == PWM_OFF) begin
            state_d = DT_OFF;
        end else begin
            unique case (state_q)
                DT_OFF, DT_L_ON, DT_H_ON: begin
                    if (ref_i && (state_q != DT_H_ON)) begin
                        state_d = dtZero ? DT_H_ON : DT_LH;
                        cnt_d   = dtLoad;
                    end else if (!ref_i && (state_q != DT_L_ON)) begin
                        state_d = dtZero ? DT_L_ON : DT_HL;
                        cnt_d   = dtLoad;
                    end
                end
                DT_LH: begin
                    if (!ref_i) begin
                        state_d = DT_L_ON;
                    end else if (cnt_q == '0) begin
                        state_d = DT_H_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                DT_HL: begin
                    if (ref_i) begin
                        state_d = DT_H_ON;
                    end else if (cnt_q == '0) begin
                        state_d = DT_L_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                default: state_d = DT_OFF;
            endcase
        end
        {pwm_h_d, pwm_l_d} = gateDecode(state_d, polarity_sh_d_i);
    end

    // State, counter and gate outputs update together so the gates are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DT_OFF;
            cnt_q   <= '0;
            pwm_h_q <= 1'b0;
            pwm_l_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_h_q <= pwm_h_d;
            pwm_l_q <= pwm_l_d;
        end
    end

    assign state_o = state_q;
    assign pwm_h_o = pwm_h_q;
    assign pwm_l_o = pwm_l_q;

endmodule

// File: rtl/pwm_compare_deadtime.sv
// One PWM leg: shadows the bus-side settings, compares the carrier against the
// shadowed compare value and drives a complementary gate pair with dead time.
module pwm_compare_deadtime
    import pwm_compare_deadtime_pkg::*;
#(
    parameter int CNT_W = PWMCOUNT_WIDTH,
    parameter int DT_W  = DEADTIME_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] carrier,
    input  logic             maskevent,
    input  logic [CNT_W-1:0] compare,
    input  logic [DT_W-1:0]  deadtime,
    input  logic             polarity_inv,
    input  pwm_onoff_e       pwm_onoff,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             compare_match
);

    logic [CNT_W-1:0] compare_sh_q, compare_sh_d;
    logic [DT_W-1:0]  deadtime_sh_q, deadtime_sh_d;
    logic             polarity_sh_q, polarity_sh_d;
    logic             ref_q, ref_d;
    logic             ref_prev_q;
    logic             match_q, match_d;
    logic             shadowLoad;
    dt_state_e        state;

    assign shadowLoad = maskevent || (pwm_onoff == PWM_OFF);

    // Shadows follow the bus side on the carrier strobe, or freely while the leg is off.
    always_comb begin
        compare_sh_d  = compare_sh_q;
        deadtime_sh_d = deadtime_sh_q;
        polarity_sh_d = polarity_sh_q;
        if (shadowLoad) begin
            compare_sh_d  = compare;
            deadtime_sh_d = deadtime;
            polarity_sh_d = polarity_inv;
        end
    end

    // Raw compare result and the edge pulse derived from its previous value.
    always_comb begin
        ref_d   = (carrier < compare_sh_q);
        match_d = (ref_q != ref_prev_q) && (state != DT_OFF);
    end

    // Shadow, ref and match registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            compare_sh_q  <= '0;
            deadtime_sh_q <= '0;
            polarity_sh_q <= 1'b0;
            ref_q         <= 1'b0;
            ref_prev_q    <= 1'b0;
            match_q       <= 1'b0;
        end else begin
            compare_sh_q  <= compare_sh_d;
            deadtime_sh_q <= deadtime_sh_d;
            polarity_sh_q <= polarity_sh_d;
            ref_q         <= ref_d;
            ref_prev_q    <= ref_q;
            match_q       <= match_d;
        end
    end

    pwm_compare_deadtime_fsm #(
        .DT_W (DT_W)
    ) uFsm (
        .clk             (clk),
        .reset           (reset),
        .ref_i           (ref_q),
        .pwm_onoff_i     (pwm_onoff),
        .deadtime_sh_i   (deadtime_sh_q),
        .polarity_sh_d_i (polarity_sh_d),
        .state_o         (state),
        .pwm_h_o         (pwm_h),
        .pwm_l_o         (pwm_l)
    );

    assign compare_match = match_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// Randomized bench for one PWM leg, checked cycle by cycle against a leg model.
module tb_pwm_compare_deadtime;
    import pwm_compare_deadtime_pkg::*;

    logic        clk;
    logic        reset;
    logic [15:0] carrier;
    logic        maskevent;
    logic [15:0] compare;
    logic [9:0]  deadtime;
    logic        polarityInv;
    pwm_onoff_e  pwmOnoff;
    logic        pwmH;
    logic        pwmL;
    logic        compareMatch;

    int compared;
    int mismatched;

    // Stimulus generator state
    int triC;
    int triMax;
    bit triUp;
    bit onReg;

    // Reference model state (values as they will appear after the next edge)
    logic [15:0] mCmpSh;
    int          mDtSh;
    bit          mPolSh;
    bit          mRef;
    bit          mRefPrev;
    bit          mMatch;
    bit          mOff;
    int          mActive;   // 0 none, 1 high leg, 2 low leg
    int          mTarget;
    int          mGap;
    bit          expH;
    bit          expL;

    pwm_compare_deadtime dut (
        .clk           (clk),
        .reset         (reset),
        .carrier       (carrier),
        .maskevent     (maskevent),
        .compare       (compare),
        .deadtime      (deadtime),
        .polarity_inv  (polarityInv),
        .pwm_onoff     (pwmOnoff),
        .pwm_h         (pwmH),
        .pwm_l         (pwmL),
        .compare_match (compareMatch)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCmpSh = '0; mDtSh = 0; mPolSh = 0;
        mRef = 0; mRefPrev = 0; mMatch = 0;
        mOff = 1; mActive = 0; mTarget = 0; mGap = 0;
        expH = 0; expL = 0;
    endtask

    // One clock of the leg behaviour, using the inputs seen at this edge.
    task automatic modelStep();
        bit load;
        bit nRef;
        bit nMatch;
        int want;
        load   = maskevent || (pwmOnoff == PWM_OFF);
        nRef   = (carrier < mCmpSh);
        nMatch = (mRef != mRefPrev) && !mOff;
        want   = mRef ? 1 : 2;
        if (pwmOnoff == PWM_OFF) begin
            mOff = 1;
            mActive = 0;
        end else if (mOff || (mActive != 0 && want != mActive)) begin
            mOff = 0;
            mTarget = want;
            if (mDtSh == 0) begin
                mActive = want;
            end else begin
                mActive = 0;
                mGap = mDtSh - 1;
            end
        end else if (mActive == 0) begin
            if (want != mTarget) mActive = want;
            else if (mGap == 0) mActive = mTarget;
            else mGap--;
        end
        if (load) begin
            mCmpSh = compare;
            mDtSh  = int'(deadtime);
            mPolSh = polarityInv;
        end
        mRefPrev = mRef;
        mRef     = nRef;
        mMatch   = nMatch;
        expH = (!mOff && mActive == 1) ? !mPolSh : mPolSh;
        expL = (!mOff && mActive == 2) ? !mPolSh : mPolSh;
    endtask

    // Triangle carrier with random period, random settings per period and
    // occasional glitches, max-value samples and unshadowed compare writes.
    task automatic applyStimulus();
        int pick;
        if (triUp) begin
            if (triC >= triMax) begin triUp = 0; triC--; end
            else triC++;
        end else if (triC == 0) begin
            triUp = 1;
            triC = 1;
        end else begin
            triC--;
        end
        maskevent = (triC == 0);
        if (triC == 0) begin
            triMax = $urandom_range(8, 40);
            pick = $urandom_range(0, 9);
            if (pick == 0) compare = 16'h0000;
            else if (pick == 1) compare = 16'hFFFF;
            else compare = 16'($urandom_range(0, triMax + 2));
            deadtime = ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 6));
            if ($urandom_range(0, 5) == 0) polarityInv = $urandom_range(0, 1) == 1;
            onReg = ($urandom_range(0, 7) != 0);
        end else if ($urandom_range(0, 19) == 0) begin
            compare = 16'($urandom_range(0, triMax));
        end
        pwmOnoff = onReg ? PWM_ON : PWM_OFF;
        if ($urandom_range(0, 49) == 0) carrier = 16'hFFFF;
        else if ($urandom_range(0, 39) == 0) carrier = 16'($urandom_range(0, 45));
        else carrier = 16'(triC);
    endtask

    task automatic checkAll();
        checkOutput("pwm_h", {31'd0, pwmH}, {31'd0, expH});
        checkOutput("pwm_l", {31'd0, pwmL}, {31'd0, expL});
        checkOutput("compare_match", {31'd0, compareMatch}, {31'd0, mMatch});
        checkOutput("overlap", {31'd0, (pwmH != mPolSh) && (pwmL != mPolSh)}, 32'd0);
    endtask

    // Main sequence: reset, randomized run, asynchronous reset mid-run, summary.
    initial begin
        bit resetDone;
        compared = 0; mismatched = 0;
        reset = 1'b0;
        carrier = '0; maskevent = 0; compare = 16'd10; deadtime = 10'd3;
        polarityInv = 0; pwmOnoff = PWM_OFF;
        triC = 0; triUp = 1; triMax = 20; onReg = 1;
        resetDone = 0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_pwm_h", {31'd0, pwmH}, 32'd0);
        checkOutput("reset_pwm_l", {31'd0, pwmL}, 32'd0);
        checkOutput("reset_match", {31'd0, compareMatch}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if (!resetDone && i >= 1500 && ((!mOff && mActive == 1) || i == 2500)) begin
                resetDone = 1;
                #1 reset = 1'b0;
                #1;
                checkOutput("midreset_pwm_h", {31'd0, pwmH}, 32'd0);
                checkOutput("midreset_pwm_l", {31'd0, pwmL}, 32'd0);
                checkOutput("midreset_match", {31'd0, compareMatch}, 32'd0);
                modelReset();
                @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
            end
            applyStimulus();
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkAll();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
